button_debouncer: RTL

- Consumes the slow `clk_button` strobe from the clock generator (counter bit 9, about 1024 clk periods per cycle at 100 MHz).
- Debounces NUM_BUTTONS raw board push-buttons, using that strobe as its sample enable.
- Produces clean levels, one-cycle press/release pulses, and auto-repeat pulses for the PONG paddle and menu logic.
- Runs entirely in the `clk` domain. `clk_button` is treated as data, never as a clock.

---
 rtl/pong_pkg.sv | 27 ++
 rtl/debounce_channel.sv | 108 ++++++++++
 rtl/button_debouncer.sv | 64 ++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared PONG package: default button count, button index constants and
// default debounce / auto-repeat settings used by the input front end.
package pong_pkg;

    localparam int NUM_BUTTONS_DEF = 4;

    // Board button assignment
    localparam int BTN_P1_UP = 0;
    localparam int BTN_P1_DN = 1;
    localparam int BTN_P2_UP = 2;
    localparam int BTN_P2_DN = 3;

    localparam bit ACTIVE_LOW_DEF     = 1'b1;
    localparam int STABLE_SAMPLES_DEF = 16;
    localparam int REPEAT_DELAY_DEF   = 64;
    localparam int REPEAT_PERIOD_DEF  = 8;

    localparam int CNT_W  = 8;
    localparam int RCNT_W = 12;

    // Auto-repeat phase: waiting for the first repeat, or repeating
    typedef enum logic {
        PH_DELAY  = 1'b0,
        PH_REPEAT = 1'b1
    } rep_phase_e;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, debounce counter, registered
// press/release pulses and auto-repeat generator.
//
// Ports:
//   clk, reset    : system clock, async active-high reset
//   tick          : one-clk sample enable shared by all channels
//   raw           : raw asynchronous button pin
//   level         : debounced state, 1 = pressed
//   press_pulse   : 1-clk pulse the cycle after level rises
//   release_pulse : 1-clk pulse the cycle after level falls
//   repeat_pulse  : 1-clk pulse with each press and each auto-repeat
module debounce_channel
    import pong_pkg::*;
#(
    parameter bit ACTIVE_LOW     = ACTIVE_LOW_DEF,
    parameter int STABLE_SAMPLES = STABLE_SAMPLES_DEF,
    parameter int REPEAT_DELAY   = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD  = REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(STABLE_SAMPLES - 1);
    localparam logic [RCNT_W-1:0] RD_LIMIT  = RCNT_W'(REPEAT_DELAY);
    localparam logic [RCNT_W-1:0] RP_LIMIT  = RCNT_W'(REPEAT_PERIOD);

    logic              sync1, sync2;
    logic              level_d;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [RCNT_W-1:0] rcnt, rcnt_n, rcnt_inc;
    rep_phase_e        phase, phase_n;
    logic              level_n;
    logic              rep_evt;

    always_comb begin
        cnt_n    = cnt;
        level_n  = level;
        rcnt_n   = rcnt;
        phase_n  = phase;
        rep_evt  = 1'b0;
        rcnt_inc = rcnt + RCNT_W'(1);

        if (tick) begin
            if (sync2 == level) begin
                cnt_n = '0;
            end else if (cnt == CNT_MAX) begin
                level_n = ~level;
                cnt_n   = '0;
            end else begin
                cnt_n = cnt + CNT_W'(1);
            end

            if (level) begin
                rcnt_n = rcnt_inc;
                if (phase == PH_DELAY && rcnt_inc == RD_LIMIT) begin
                    rep_evt = 1'b1;
                    rcnt_n  = '0;
                    phase_n = PH_REPEAT;
                end else if (phase == PH_REPEAT && rcnt_inc == RP_LIMIT) begin
                    rep_evt = 1'b1;
                    rcnt_n  = '0;
                end
            end
        end

        // Released, or releasing on this tick: repeat machine idles and a
        // coincident repeat boundary is dropped in favour of the release.
        if (!level || !level_n) begin
            rcnt_n  = '0;
            phase_n = PH_DELAY;
            rep_evt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1         <= 1'b0;
            sync2         <= 1'b0;
            level         <= 1'b0;
            level_d       <= 1'b0;
            cnt           <= '0;
            rcnt          <= '0;
            phase         <= PH_DELAY;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            sync1         <= raw ^ ACTIVE_LOW;
            sync2         <= sync1;
            level         <= level_n;
            level_d       <= level;
            cnt           <= cnt_n;
            rcnt          <= rcnt_n;
            phase         <= phase_n;
            press_pulse   <= level & ~level_d;
            release_pulse <= ~level & level_d;
            repeat_pulse  <= (level & ~level_d) | rep_evt;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Debounces NUM_BUTTONS board push-buttons using the slow clk_button strobe
// as a sample enable. clk_button is sampled as data; each rising edge gives
// a single one-clk tick shared by all channels.
//
// Ports:
//   clk         : 100 MHz system clock
//   reset       : asynchronous active-high reset
//   clk_button  : divided strobe, one sample tick per rising edge
//   btn_raw     : raw asynchronous button pins
//   btn_level   : debounced state, 1 = pressed
//   btn_press   : 1-clk pulse on each 0->1 of btn_level
//   btn_release : 1-clk pulse on each 1->0 of btn_level
//   btn_repeat  : 1-clk pulse on press and on each auto-repeat while held
module button_debouncer
    import pong_pkg::*;
#(
    parameter int NUM_BUTTONS    = NUM_BUTTONS_DEF,
    parameter bit ACTIVE_LOW     = ACTIVE_LOW_DEF,
    parameter int STABLE_SAMPLES = STABLE_SAMPLES_DEF,
    parameter int REPEAT_DELAY   = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD  = REPEAT_PERIOD_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clk_button,
    input  logic [NUM_BUTTONS-1:0] btn_raw,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] btn_press,
    output logic [NUM_BUTTONS-1:0] btn_release,
    output logic [NUM_BUTTONS-1:0] btn_repeat
);

    logic prev;
    logic tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= 1'b0;
        end else begin
            prev <= clk_button;
        end
    end

    assign tick = clk_button & ~prev;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
        debounce_channel #(
            .ACTIVE_LOW     (ACTIVE_LOW),
            .STABLE_SAMPLES (STABLE_SAMPLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_chan (
            .clk           (clk),
            .reset         (reset),
            .tick          (tick),
            .raw           (btn_raw[i]),
            .level         (btn_level[i]),
            .press_pulse   (btn_press[i]),
            .release_pulse (btn_release[i]),
            .repeat_pulse  (btn_repeat[i])
        );
    end

endmodule
